// File: rtl/fma16_pkg.sv
// Shared types for the fma16 request controller: opcodes, FSM states,
// flag bit positions and the datapath control tuple.
package fma16_pkg;

   typedef enum logic [2:0] {
      OP_FADD   = 3'd0,
      OP_FSUB   = 3'd1,
      OP_FMUL   = 3'd2,
      OP_FMADD  = 3'd3,
      OP_FMSUB  = 3'd4,
      OP_FNMADD = 3'd5,
      OP_FNMSUB = 3'd6,
      OP_ILL    = 3'd7
   } op_t;

   typedef enum logic [1:0] {
      S_IDLE,
      S_EXEC,
      S_RESP
   } state_t;

   localparam int unsigned FLAG_NV = 3;
   localparam int unsigned FLAG_OF = 2;
   localparam int unsigned FLAG_UF = 1;
   localparam int unsigned FLAG_NX = 0;

   typedef struct packed {
      logic mul;
      logic add;
      logic negr;
      logic negz;
   } ctrl_t;

   function automatic ctrl_t decode(input op_t op);
      ctrl_t c;
      case (op)
         OP_FADD:   c = 4'b0100;
         OP_FSUB:   c = 4'b0101;
         OP_FMUL:   c = 4'b1000;
         OP_FMADD:  c = 4'b1100;
         OP_FMSUB:  c = 4'b1101;
         OP_FNMADD: c = 4'b1110;
         OP_FNMSUB: c = 4'b1111;
         default:   c = '0;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/fma16.sv
// Combinational half-precision fused multiply-add: ((x*y) or x) +/- (z or y),
// optionally negated, rounded once with RNE/RTZ/RDN/RUP; flags {NV,OF,UF,NX}.
module fma16
   import fma16_pkg::*;
(
   input  logic [15:0] x,
   input  logic [15:0] y,
   input  logic [15:0] z,
   input  logic [1:0]  rm,
   input  logic        mul,
   input  logic        add,
   input  logic        negr,
   input  logic        negz,
   output logic [15:0] result,
   output logic [3:0]  flags
);

   localparam int unsigned W = 82;

   logic [15:0]  a, b, c;
   logic         sp, sc, sr;
   logic [4:0]   ea, eb, ec;
   logic [10:0]  ma, mb, mc, mant;
   logic         anan, bnan, cnan, ainf, binf, cinf, azero, bzero;
   logic         snan, invalid, guard, sticky, inc, ovf_inf;
   logic [21:0]  pm;
   logic [W-1:0] pmag, zmag, mag, lowmask;
   int unsigned  lead, lsb, rbits;

   always_comb begin
      a  = x;
      b  = mul ? y : 16'h3C00;
      sp = a[15] ^ b[15] ^ negr;
      // Without an addend, a zero of the product's sign leaves the product untouched.
      c  = add ? (mul ? z : y) : 16'h0000;
      sc = add ? (c[15] ^ negz ^ negr) : sp;

      ea = (a[14:10] == 5'd0) ? 5'd1 : a[14:10];
      eb = (b[14:10] == 5'd0) ? 5'd1 : b[14:10];
      ec = (c[14:10] == 5'd0) ? 5'd1 : c[14:10];
      ma = {|a[14:10], a[9:0]};
      mb = {|b[14:10], b[9:0]};
      mc = {|c[14:10], c[9:0]};

      anan  = (&a[14:10]) & (|a[9:0]);
      bnan  = (&b[14:10]) & (|b[9:0]);
      cnan  = (&c[14:10]) & (|c[9:0]);
      ainf  = (&a[14:10]) & ~(|a[9:0]);
      binf  = (&b[14:10]) & ~(|b[9:0]);
      cinf  = (&c[14:10]) & ~(|c[9:0]);
      azero = ~(|a[14:0]);
      bzero = ~(|b[14:0]);
      snan  = (anan & ~a[9]) | (bnan & ~b[9]) | (cnan & ~c[9]);
      invalid = snan | (ainf & bzero) | (azero & binf) |
                ((ainf | binf) & cinf & (sp != sc));

      // Exact fixed-point sum, LSB weight 2^-48.
      pm   = ma * mb;
      pmag = W'(pm) << ({2'b0, ea} + {2'b0, eb} - 7'd2);
      zmag = W'(mc) << ({2'b0, ec} + 7'd23);
      if (sp == sc) begin
         mag = pmag + zmag;
         sr  = sp;
      end else if (pmag >= zmag) begin
         mag = pmag - zmag;
         sr  = (pmag == zmag) ? (rm == 2'd2) : sp;
      end else begin
         mag = zmag - pmag;
         sr  = sc;
      end

      lead = 0;
      for (int unsigned i = 0; i < W; i++)
         if (mag[i]) lead = i;
      lsb     = (lead >= 34) ? lead - 10 : 24;
      mant    = 11'(mag >> lsb);
      lowmask = (W'(1) << (lsb - 1)) - W'(1);
      guard   = |(mag & (W'(1) << (lsb - 1)));
      sticky  = |(mag & lowmask);
      case (rm)
         2'd0:    inc = guard & (sticky | mant[0]);
         2'd2:    inc = sr & (guard | sticky);
         2'd3:    inc = ~sr & (guard | sticky);
         default: inc = 1'b0;
      endcase
      // Exponent and significand add together so a rounding carry bumps the exponent.
      rbits   = ((lsb - 24) << 10) + {21'b0, mant} + {31'b0, inc};
      ovf_inf = (rm == 2'd0) | ((rm == 2'd2) & sr) | ((rm == 2'd3) & ~sr);

      result = '0;
      flags  = '0;
      if (anan | bnan | cnan | invalid) begin
         result         = 16'h7E00;
         flags[FLAG_NV] = invalid;
      end else if (ainf | binf) begin
         result = {sp, 15'h7C00};
      end else if (cinf) begin
         result = {sc, 15'h7C00};
      end else if (rbits >= 32'h7C00) begin
         result         = ovf_inf ? {sr, 15'h7C00} : {sr, 15'h7BFF};
         flags[FLAG_OF] = 1'b1;
         flags[FLAG_NX] = 1'b1;
      end else begin
         result         = {sr, rbits[14:0]};
         flags[FLAG_NX] = guard | sticky;
         flags[FLAG_UF] = (guard | sticky) & (lead < 34);
      end
   end

endmodule

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter with a last-grant pointer; grants only when en.
module rr_arb2 (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       en,
   input  logic [1:0] valid,
   output logic [1:0] grant,
   output logic       gid
);

   logic last;

   always_comb begin
      grant = '0;
      gid   = 1'b0;
      if (en) begin
         case (valid)
            2'b01: begin grant = 2'b01; gid = 1'b0; end
            2'b10: begin grant = 2'b10; gid = 1'b1; end
            2'b11: begin
               gid   = ~last;
               grant = last ? 2'b01 : 2'b10;
            end
            default: ;
         endcase
      end
   end

   // Reset value 1 makes requester 0 win the first tie.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)    last <= 1'b1;
      else if (|grant) last <= gid;
   end

endmodule

// File: rtl/fma16_ctrl.sv
// Two-requester front end for the fma16 datapath: round-robin accept,
// one-cycle execute, held response and sticky exception flags.
module fma16_ctrl
   import fma16_pkg::*;
#(
   parameter logic [15:0] CANON_NAN = 16'h7E00
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [1:0]       req_valid,
   output logic [1:0]       req_ready,
   input  logic [1:0][2:0]  req_op,
   input  logic [1:0][15:0] req_x,
   input  logic [1:0][15:0] req_y,
   input  logic [1:0][15:0] req_z,
   input  logic [1:0][1:0]  req_rm,
   output logic             resp_valid,
   input  logic             resp_ready,
   output logic             resp_id,
   output logic [15:0]      resp_result,
   output logic [3:0]       resp_flags,
   output logic [3:0]       fflags,
   input  logic             fflags_clr
);

   state_t      state, state_nx;
   logic [1:0]  grant;
   logic        gid, req_hs, resp_hs;
   op_t         op_q;
   logic [15:0] x_q, y_q, z_q, res_q, dp_result;
   logic [1:0]  rm_q;
   logic        id_q;
   logic [3:0]  flg_q, dp_flags;
   ctrl_t       ctl;

   // Gating with reset_n keeps req_ready low while reset is held.
   rr_arb2 u_arb (
      .clk     (clk),
      .reset_n (reset_n),
      .en      ((state == S_IDLE) & reset_n),
      .valid   (req_valid),
      .grant   (grant),
      .gid     (gid)
   );

   assign req_hs  = |(req_valid & req_ready);
   assign resp_hs = resp_valid & resp_ready;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= S_IDLE;
      else          state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE:  if (req_hs)  state_nx = S_EXEC;
         S_EXEC:  state_nx = S_RESP;
         S_RESP:  if (resp_hs) state_nx = S_IDLE;
         default: state_nx = S_IDLE;
      endcase
   end

   always_comb begin
      req_ready  = '0;
      resp_valid = 1'b0;
      case (state)
         S_IDLE:  req_ready  = grant;
         S_RESP:  resp_valid = 1'b1;
         default: ;
      endcase
   end

   assign ctl = decode(op_q);

   fma16 u_dp (
      .x      (x_q),
      .y      (y_q),
      .z      (z_q),
      .rm     (rm_q),
      .mul    (ctl.mul),
      .add    (ctl.add),
      .negr   (ctl.negr),
      .negz   (ctl.negz),
      .result (dp_result),
      .flags  (dp_flags)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         op_q  <= OP_FADD;
         x_q   <= '0;
         y_q   <= '0;
         z_q   <= '0;
         rm_q  <= '0;
         id_q  <= 1'b0;
         res_q <= '0;
         flg_q <= '0;
      end else begin
         if (req_hs) begin
            op_q <= op_t'(req_op[gid]);
            x_q  <= req_x[gid];
            y_q  <= req_y[gid];
            z_q  <= req_z[gid];
            rm_q <= req_rm[gid];
            id_q <= gid;
         end
         if (state == S_EXEC) begin
            res_q <= (op_q == OP_ILL) ? CANON_NAN : dp_result;
            flg_q <= (op_q == OP_ILL) ? 4'b1000   : dp_flags;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)       fflags <= '0;
      else if (fflags_clr) fflags <= resp_hs ? flg_q : '0;
      else if (resp_hs)   fflags <= fflags | flg_q;
   end

   assign resp_id     = id_q;
   assign resp_result = res_q;
   assign resp_flags  = flg_q;

endmodule

// File: tb/tb_fma16_ctrl.sv
// Directed bench for fma16_ctrl: handshake timing, arbitration, datapath
// vectors, backpressure, flag accumulation/clear and mid-operation reset.
module tb_fma16_ctrl;

   logic             clk;
   logic             reset_n;
   logic [1:0]       req_valid;
   logic [1:0]       req_ready;
   logic [1:0][2:0]  req_op;
   logic [1:0][15:0] req_x, req_y, req_z;
   logic [1:0][1:0]  req_rm;
   logic             resp_valid, resp_ready, resp_id, fflags_clr;
   logic [15:0]      resp_result;
   logic [3:0]       resp_flags, fflags;

   int checks = 0;
   int errors = 0;

   fma16_ctrl #(.CANON_NAN(16'h7E00)) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_op      (req_op),
      .req_x       (req_x),
      .req_y       (req_y),
      .req_z       (req_z),
      .req_rm      (req_rm),
      .resp_valid  (resp_valid),
      .resp_ready  (resp_ready),
      .resp_id     (resp_id),
      .resp_result (resp_result),
      .resp_flags  (resp_flags),
      .fflags      (fflags),
      .fflags_clr  (fflags_clr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog expired");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic set_req(input logic r, input logic [2:0] op, input logic [15:0] xx,
                          input logic [15:0] yy, input logic [15:0] zz, input logic [1:0] rr);
      req_op[r] = op;
      req_x[r]  = xx;
      req_y[r]  = yy;
      req_z[r]  = zz;
      req_rm[r] = rr;
   endtask

   // One complete operation on a single requester with resp_ready held high.
   task automatic do_op(input string tag, input logic r, input logic [2:0] op,
                        input logic [15:0] xx, input logic [15:0] yy, input logic [15:0] zz,
                        input logic [1:0] rr, input logic [15:0] er, input logic [3:0] ef);
      set_req(r, op, xx, yy, zz, rr);
      req_valid  = r ? 2'b10 : 2'b01;
      resp_ready = 1'b1;
      #1;
      check({tag, "_ready"}, 16'(req_ready), r ? 16'h2 : 16'h1);
      tick();
      req_valid = 2'b00;
      req_x[r]  = ~xx;
      tick();
      check({tag, "_valid"}, 16'(resp_valid), 16'h1);
      check({tag, "_res"},   resp_result, er);
      check({tag, "_flags"}, 16'(resp_flags), 16'(ef));
      check({tag, "_id"},    16'(resp_id), 16'(r));
      tick();
   endtask

   initial begin
      reset_n    = 1'b0;
      req_valid  = 2'b01;
      req_op     = '0;
      req_x      = '0;
      req_y      = '0;
      req_z      = '0;
      req_rm     = '0;
      resp_ready = 1'b1;
      fflags_clr = 1'b0;
      set_req(1'b0, 3'd2, 16'h3C00, 16'h4000, 16'h0000, 2'd0);
      tick();
      tick();
      check("rst_req_ready",  16'(req_ready), 16'h0);
      check("rst_resp_valid", 16'(resp_valid), 16'h0);
      check("rst_resp_id",    16'(resp_id), 16'h0);
      check("rst_resp_result", resp_result, 16'h0);
      check("rst_resp_flags", 16'(resp_flags), 16'h0);
      check("rst_fflags",     16'(fflags), 16'h0);

      // Single fmul accepted on the first edge after reset release.
      reset_n = 1'b1;
      #1;
      check("first_ready", 16'(req_ready), 16'h1);
      tick();
      check("exec_ready", 16'(req_ready), 16'h0);
      check("exec_valid", 16'(resp_valid), 16'h0);
      req_valid = 2'b00;
      req_x[0]  = 16'h5555;
      tick();
      check("single_valid", 16'(resp_valid), 16'h1);
      check("single_res",   resp_result, 16'h4000);
      check("single_flags", 16'(resp_flags), 16'h0);
      check("single_id",    16'(resp_id), 16'h0);
      tick();
      check("single_done", 16'(resp_valid), 16'h0);
      check("single_fflags", 16'(fflags), 16'h0);

      do_op("fmadd",   1'b0, 3'd3, 16'h4000, 16'h4000, 16'h3C00, 2'd0, 16'h4500, 4'h0);
      do_op("fnmadd",  1'b0, 3'd5, 16'h4000, 16'h4000, 16'h3C00, 2'd0, 16'hC500, 4'h0);
      do_op("fmsub",   1'b1, 3'd4, 16'h4000, 16'h3C00, 16'h3C00, 2'd0, 16'h3C00, 4'h0);
      do_op("fsub_rne", 1'b0, 3'd1, 16'h3C00, 16'h3C00, 16'h0000, 2'd0, 16'h0000, 4'h0);
      do_op("fsub_rdn", 1'b0, 3'd1, 16'h3C00, 16'h3C00, 16'h0000, 2'd2, 16'h8000, 4'h0);
      check("exact_fflags", 16'(fflags), 16'h0);

      // Illegal opcode from requester 1.
      do_op("illegal", 1'b1, 3'd7, 16'h3C00, 16'h3C00, 16'h3C00, 2'd0, 16'h7E00, 4'h8);
      check("illegal_fflags", 16'(fflags), 16'h8);

      // Tie: both requesters present fadd continuously.
      set_req(1'b0, 3'd0, 16'h3C00, 16'h3C00, 16'h0000, 2'd0);
      set_req(1'b1, 3'd0, 16'h3C00, 16'h3C00, 16'h0000, 2'd0);
      req_valid = 2'b11;
      for (int k = 0; k < 4; k++) begin
         #1;
         check("tie_grant", 16'(req_ready), (k % 2 == 0) ? 16'h1 : 16'h2);
         tick();
         check("tie_exec_ready", 16'(req_ready), 16'h0);
         tick();
         check("tie_res", resp_result, 16'h4000);
         check("tie_id",  16'(resp_id), (k % 2 == 0) ? 16'h0 : 16'h1);
         tick();
      end
      req_valid = 2'b00;

      // Backpressure: response held for five cycles while both requesters wait.
      set_req(1'b0, 3'd6, 16'h4000, 16'h4000, 16'h3C00, 2'd0);
      req_valid  = 2'b01;
      resp_ready = 1'b0;
      #1;
      tick();
      req_valid = 2'b11;
      tick();
      for (int k = 0; k < 5; k++) begin
         check("bp_valid", 16'(resp_valid), 16'h1);
         check("bp_res",   resp_result, 16'hC200);
         check("bp_flags", 16'(resp_flags), 16'h0);
         check("bp_id",    16'(resp_id), 16'h0);
         check("bp_ready", 16'(req_ready), 16'h0);
         req_x[0] = 16'($urandom);
         tick();
      end
      check("bp_still_valid", 16'(resp_valid), 16'h1);
      req_valid  = 2'b00;
      resp_ready = 1'b1;
      tick();
      check("bp_released", 16'(resp_valid), 16'h0);
      tick();
      check("bp_single_hs", 16'(resp_valid), 16'h0);
      check("bp_fflags", 16'(fflags), 16'h8);

      // Clear coincident with a response carrying NX.
      set_req(1'b0, 3'd0, 16'h3C00, 16'h0001, 16'h0000, 2'd0);
      req_valid = 2'b01;
      #1;
      tick();
      req_valid = 2'b00;
      tick();
      check("clr_res",   resp_result, 16'h3C00);
      check("clr_flags", 16'(resp_flags), 16'h1);
      check("clr_pre_fflags", 16'(fflags), 16'h8);
      fflags_clr = 1'b1;
      tick();
      fflags_clr = 1'b0;
      check("clr_hs_fflags", 16'(fflags), 16'h1);
      fflags_clr = 1'b1;
      tick();
      fflags_clr = 1'b0;
      check("clr_idle_fflags", 16'(fflags), 16'h0);

      do_op("ovf_rne", 1'b1, 3'd2, 16'h7BFF, 16'h7BFF, 16'h0000, 2'd0, 16'h7C00, 4'h5);
      do_op("ovf_rtz", 1'b0, 3'd2, 16'h7BFF, 16'h7BFF, 16'h0000, 2'd1, 16'h7BFF, 4'h5);
      do_op("unf_rne", 1'b0, 3'd2, 16'h0400, 16'h0400, 16'h0000, 2'd0, 16'h0000, 4'h3);
      do_op("unf_rup", 1'b1, 3'd2, 16'h0400, 16'h0400, 16'h0000, 2'd3, 16'h0001, 4'h3);
      check("partial_fflags", 16'(fflags), 16'h7);
      do_op("snan",    1'b0, 3'd0, 16'h7C01, 16'h3C00, 16'h0000, 2'd0, 16'h7E00, 4'h8);
      do_op("inf_sub", 1'b1, 3'd1, 16'h7C00, 16'h7C00, 16'h0000, 2'd0, 16'h7E00, 4'h8);
      check("all_fflags", 16'(fflags), 16'hF);

      // Reset while an operation from requester 0 is executing.
      set_req(1'b0, 3'd2, 16'h3C00, 16'h4000, 16'h0000, 2'd0);
      req_valid = 2'b01;
      #1;
      tick();
      req_valid = 2'b00;
      reset_n   = 1'b0;
      #1;
      check("mid_rst_valid",  16'(resp_valid), 16'h0);
      check("mid_rst_ready",  16'(req_ready), 16'h0);
      check("mid_rst_result", resp_result, 16'h0);
      check("mid_rst_flags",  16'(resp_flags), 16'h0);
      check("mid_rst_fflags", 16'(fflags), 16'h0);
      tick();
      reset_n = 1'b1;
      for (int k = 0; k < 3; k++) begin
         tick();
         check("mid_rst_no_resp", 16'(resp_valid), 16'h0);
      end
      set_req(1'b0, 3'd0, 16'h3C00, 16'h3C00, 16'h0000, 2'd0);
      set_req(1'b1, 3'd0, 16'h3C00, 16'h3C00, 16'h0000, 2'd0);
      req_valid = 2'b11;
      #1;
      check("post_rst_tie", 16'(req_ready), 16'h1);
      tick();
      req_valid = 2'b00;
      tick();
      check("post_rst_res", resp_result, 16'h4000);
      check("post_rst_id",  16'(resp_id), 16'h0);
      tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
